instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the calculator execute/decode block.
- Owns the program counter and drives the 16-word instruction ROM; the ROM is combinational, with `data` valid in the same cycle as `address`.
- Buffers fetched words in a small FIFO and presents them to the execute stage with a valid/ready handshake, so execute stalls never lose or duplicate instructions.
- Supports flush/redirect to a new PC and end-of-program detection.

Parameters:
- W, 32, instruction word width.
- L, 16, ROM depth in words; PC width is $clog2(L).
- DEPTH, 2, prefetch FIFO entries; must be a power of two, ≥ 2.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  fetch permission (the `opera` level); when low, no new ROM reads are enqueued.
- rom_address  output  $clog2(L)  ROM word address; always equals fetch_pc.
- rom_oe  output  1  ROM output enable; equals `fetch_allowed` (defined below).
- rom_data  input  W  ROM read data for rom_address; same-cycle.
- flush  input  1  redirect request.
- flush_pc  input  $clog2(L)  new fetch address when flush=1.
- instr  output  W  instruction at the FIFO head.
- instr_pc  output  $clog2(L)  address that `instr` was fetched from.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  execute stage accepts the head this cycle.
- done  output  1  program finished: fetching stopped and FIFO empty.

Behaviour:
- Reset (async, immediate on reset=1):
  - fetch_pc=0, count=0, stopped=0.
  - instr=0, instr_pc=0, instr_valid=0, done=0, rom_oe=0.
  - Reset asserted mid-operation discards all buffered words; there is no partial state.
- fetch_allowed = enable & !stopped & !flush & (count<DEPTH | instr_ready).
  - A full FIFO with instr_ready=1 may enqueue and dequeue in the same cycle; count is unchanged.
- Enqueue: at posedge with fetch_allowed=1:
  - If rom_data != 0: push {rom_data, fetch_pc} into the FIFO.
  - If rom_data == 0: treat it as the HALT word. Do not push it; set stopped=1; fetch_pc holds.
  - After a non-HALT enqueue:
    - fetch_pc == L-1: set stopped=1, with no wrap-around. fetch_pc holds at L-1.
    - Otherwise fetch_pc increments by 1.
- Dequeue: at posedge with instr_valid & instr_ready, pop the head. instr_ready while empty is ignored.
- Outputs:
  - instr and instr_pc reflect the head entry combinationally from FIFO storage; they are 0 when empty.
  - instr_valid = (count != 0).
- Latency: with enable=1 and the FIFO empty, ROM word k appears on instr with instr_valid=1 one cycle after the edge where fetch_pc=k. This gives a throughput of 1 instruction/cycle when instr_ready is held high.
- Flush has priority over enqueue and dequeue. At a posedge with flush=1:
  - FIFO cleared (count=0), fetch_pc=flush_pc, stopped=0.
  - No enqueue or dequeue that cycle.
  - instr_valid=0 in the following cycle.
- done = stopped & (count==0), registered-equivalent (it changes only at clock edges). done clears on flush or reset.
- enable low: fetch_pc and stopped hold; dequeue continues normally.
- FIFO implementation: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count of $clog2(DEPTH)+1 bits. Full and empty are distinguished by count, never by pointer equality.

Test Plan:
- Straight stream:
  - Stimulus: ROM[0..3]=0x00500093, 0x00300113, 0x002081B3, 0x00000000; enable=1, instr_ready=1 after reset.
  - Required: instr=0x00500093/pc0, 0x00300113/pc1, 0x002081B3/pc2 on consecutive cycles starting 1 cycle after reset release. HALT is never presented. done=1 the cycle after the last pop; fetch_pc=3.
- Backpressure:
  - Stimulus: same ROM, instr_ready=0 for 5 cycles, then 1.
  - Required: count saturates at 2 and fetch_pc stops at 2. instr holds 0x00500093 (pc0) stable while ready=0. The order 0,1,2 resumes with no loss or duplicates.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, instr_ready=1, enable=1.
  - Required: one pop and one push in the same cycle; count stays 2; fetch_pc advances by 1.
- End of ROM without HALT:
  - Stimulus: all 16 ROM words nonzero.
  - Required: 16 instructions delivered with pc 0..15; stopped after pc 15 with no wrap to 0; done=1 after the final pop.
- Flush mid-stream:
  - Stimulus: during the stream with 2 entries buffered, pulse flush=1 with flush_pc=9.
  - Required: instr_valid=0 the next cycle; the next delivered instruction is ROM[9] with instr_pc=9. Flush asserted together with instr_ready causes no pop.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges while valid=1.
  - Required: instr_valid, done and rom_oe go to 0 immediately. After release, fetch restarts from pc 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: the ROM read port and the valid/ready handshake
// toward the execute stage. The master side is the fetch stage.
interface instr_fetch_if #(
  parameter int W  = 32,
  parameter int AW = 4
);
  logic [AW-1:0] rom_address;
  logic          rom_oe;
  logic [W-1:0]  rom_data;
  logic [W-1:0]  instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output rom_address, rom_oe, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_address, rom_oe, instr, instr_pc, instr_valid,
    output rom_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and
// buffers words in a small circular prefetch FIFO for the execute stage.
// A zero ROM word is the HALT marker and is never delivered; reaching the
// last ROM word also stops fetching (no wrap-around).
module instr_fetch #(
  parameter int W     = 32,
  parameter int L     = 16,
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [$clog2(L)-1:0] flush_pc,
  output logic                 done,
  instr_fetch_if.master        bus
);
  localparam int AW = $clog2(L);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic          stopped;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [W-1:0]  mem_word [DEPTH];
  logic [AW-1:0] mem_pc   [DEPTH];

  logic fetch_allowed;
  logic is_halt;
  logic do_push;
  logic do_pop;

  // Fetch/handshake decisions; reset gates the ROM enable so it drops at once.
  always_comb begin
    fetch_allowed = !reset && enable && !stopped && !flush &&
                    ((count < CW'(DEPTH)) || bus.instr_ready);
    is_halt       = (bus.rom_data == '0);
    do_push       = fetch_allowed && !is_halt;
    do_pop        = !flush && (count != '0) && bus.instr_ready;
  end

  assign bus.rom_address = fetch_pc;
  assign bus.rom_oe      = fetch_allowed;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = (count != '0) ? mem_word[rd_ptr] : '0;
  assign bus.instr_pc    = (count != '0) ? mem_pc[rd_ptr]   : '0;
  assign done            = stopped && (count == '0);

  // FIFO storage; contents are only visible through count, so no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_word[wr_ptr] <= bus.rom_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

  // PC, stop flag and FIFO bookkeeping; flush overrides push and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
      stopped  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush) begin
      fetch_pc <= flush_pc;
      stopped  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fetch_allowed) begin
        if (is_halt)
          stopped <= 1'b1;
        else if (fetch_pc == AW'(L - 1))
          stopped <= 1'b1;
        else
          fetch_pc <= fetch_pc + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, multi-cycle corner sequences
// and a randomized run against a queue-based reference model.
module tb_instr_fetch;
  localparam int W     = 32;
  localparam int L     = 16;
  localparam int DEPTH = 2;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          ready = 1'b0;
  logic          done;
  logic [W-1:0]  rom_mem [L];

  instr_fetch_if #(.W(W), .AW(AW)) bus ();

  assign bus.rom_data    = rom_mem[bus.rom_address];
  assign bus.instr_ready = ready;

  instr_fetch #(.W(W), .L(L), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .flush    (flush),
    .flush_pc (flush_pc),
    .done     (done),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int vec_count  = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: delivered-word queue plus the fetch pointer and stop flag.
  typedef struct {
    logic [W-1:0]  w;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  ent_t delivered[$];
  int   m_pc;
  bit   m_stopped;

  task automatic model_reset();
    mq.delete();
    m_pc      = 0;
    m_stopped = 0;
  endtask

  function automatic bit model_oe();
    return enable && !m_stopped && !flush && ((mq.size() < DEPTH) || ready);
  endfunction

  task automatic model_check();
    logic [W-1:0]  e_instr;
    logic [AW-1:0] e_pc;
    e_instr = (mq.size() != 0) ? mq[0].w  : '0;
    e_pc    = (mq.size() != 0) ? mq[0].pc : '0;
    check("valid", bus.instr_valid, 32'(mq.size() != 0));
    check("instr", bus.instr, e_instr);
    check("instr_pc", bus.instr_pc, 32'(e_pc));
    check("done", done, 32'(m_stopped && (mq.size() == 0)));
    check("rom_address", bus.rom_address, 32'(m_pc));
    check("rom_oe", bus.rom_oe, 32'(model_oe()));
  endtask

  task automatic model_step();
    bit           allow;
    logic [W-1:0] word;
    if (flush) begin
      mq.delete();
      m_pc      = int'(flush_pc);
      m_stopped = 0;
      return;
    end
    allow = model_oe();
    word  = rom_mem[m_pc];
    if (mq.size() != 0 && ready) mq.delete(0);
    if (allow) begin
      if (word == '0) m_stopped = 1;
      else begin
        mq.push_back('{word, AW'(m_pc)});
        if (m_pc == L - 1) m_stopped = 1;
        else m_pc++;
      end
    end
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic tick(input bit chk);
    #1;
    if (bus.instr_valid && ready && !flush) delivered.push_back('{bus.instr, bus.instr_pc});
    if (chk) model_check();
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < L; i++) rom_mem[i] = '0;
    rom_mem[0] = 32'h0050_0093;
    rom_mem[1] = 32'h0030_0113;
    rom_mem[2] = 32'h0020_81B3;
    rom_mem[3] = 32'h0000_0000;
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [31:0] e_instr;
    int          e_pc;
    bit          e_valid;
    bit          e_done;
    int          e_addr;
    bit          e_oe;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // straight stream
    tbl.push_back('{1, 1, 32'h0,          0, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 32'h0050_0093, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 1, 32'h0030_0113, 1, 1, 0, 2, 1});
    tbl.push_back('{0, 1, 32'h0020_81B3, 2, 1, 0, 3, 1});
    tbl.push_back('{0, 1, 32'h0,          0, 0, 1, 3, 0});
    // backpressure, then full FIFO with simultaneous push and pop
    tbl.push_back('{1, 0, 32'h0,          0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 32'h0050_0093, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 32'h0050_0093, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 0, 32'h0050_0093, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 0, 32'h0050_0093, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 1, 32'h0050_0093, 0, 1, 0, 2, 1});
    tbl.push_back('{0, 1, 32'h0030_0113, 1, 1, 0, 3, 1});
    tbl.push_back('{0, 1, 32'h0020_81B3, 2, 1, 0, 3, 0});
    tbl.push_back('{0, 1, 32'h0,          0, 0, 1, 3, 0});

    load_program();
    @(negedge clock);

    // reset state, with enable high to show the ROM enable is gated
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    check("reset_valid", bus.instr_valid, 32'd0);
    check("reset_done", done, 32'd0);
    check("reset_oe", bus.rom_oe, 32'd0);
    check("reset_instr", bus.instr, 32'd0);
    model_reset();
    @(negedge clock);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      enable = 1'b1;
      ready  = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].e_instr);
      check($sformatf("tbl%0d_pc", i), bus.instr_pc, 32'(tbl[i].e_pc));
      check($sformatf("tbl%0d_valid", i), bus.instr_valid, 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_done", i), done, 32'(tbl[i].e_done));
      check($sformatf("tbl%0d_addr", i), bus.rom_address, 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_oe", i), bus.rom_oe, 32'(tbl[i].e_oe));
      model_step();
      @(negedge clock);
    end

    // end of ROM without HALT: 16 words, no wrap
    for (int i = 0; i < L; i++) rom_mem[i] = $urandom() | 32'h1;
    do_reset();
    delivered.delete();
    enable = 1'b1;
    ready  = 1'b1;
    for (int c = 0; c < 22; c++) tick(1);
    check("eor_count", delivered.size(), 32'd16);
    for (int i = 0; i < delivered.size() && i < L; i++) begin
      check($sformatf("eor_pc%0d", i), delivered[i].pc, 32'(i));
      check($sformatf("eor_w%0d", i), delivered[i].w, rom_mem[i]);
    end
    #1;
    check("eor_done", done, 32'd1);
    check("eor_addr", bus.rom_address, 32'd15);
    @(negedge clock);

    // flush mid-stream with two entries buffered and ready high
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    tick(1);
    tick(1);
    tick(1);
    flush    = 1'b1;
    flush_pc = 4'd9;
    ready    = 1'b1;
    delivered.delete();
    tick(1);
    flush = 1'b0;
    #1;
    check("flush_valid", bus.instr_valid, 32'd0);
    tick(1);
    #1;
    check("flush_instr", bus.instr, rom_mem[9]);
    check("flush_pc", bus.instr_pc, 32'd9);
    tick(1);
    check("flush_first", (delivered.size() != 0) ? 32'(delivered[0].pc) : 32'hFFFF_FFFF, 32'd9);

    // async reset between edges while valid
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    tick(1);
    tick(1);
    #2;
    check("arst_pre_valid", bus.instr_valid, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_valid", bus.instr_valid, 32'd0);
    check("arst_done", done, 32'd0);
    check("arst_oe", bus.rom_oe, 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b1;
    tick(1);
    #1;
    check("arst_restart_valid", bus.instr_valid, 32'd1);
    check("arst_restart_pc", bus.instr_pc, 32'd0);
    tick(1);

    // randomized run against the reference model
    for (int i = 0; i < L; i++) rom_mem[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom() | 32'h1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      enable   = ($urandom_range(0, 7) != 0);
      ready    = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      flush_pc = AW'($urandom_range(0, L - 1));
      tick(1);
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end
endmodule
